pipe_pc_unit: RTL and testbench

//   Parametrised fetch-stage program counter for the pipelined CPU. Holds the PC, generates the

---
 rtl/pipe_pc_pkg.sv | 15 +
 rtl/pipe_pc_if.sv | 27 ++
 rtl/pipe_pc_redirect_buf.sv | 46 ++++
 rtl/pipe_pc_unit.sv | 152 +++++++++++++++
 tb/tb_pipe_pc_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pc_pkg.sv
// Shared types for the fetch-stage program counter: FSM states, next-PC select and
// redirect kinds, plus the alignment helper used by the optional misalignment trap.
package pipe_pc_pkg;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} pc_state_t;

    typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_PEND, SEL_EXC} next_sel_t;

    typedef enum logic [1:0] {NONE, BR, EXC} redir_kind_t;

    function automatic logic is_misaligned(input logic [63:0] target, input int unsigned inc);
        return (target % 64'(inc)) != 64'd0;
    endfunction

endpackage

// File: rtl/pipe_pc_if.sv
// Fetch-PC bus: redirect/stall requests from the pipeline (master) and the PC state
// published by pipe_pc_unit (slave).
interface pipe_pc_if #(
    parameter int unsigned PC_W = 32
);
    logic            pc_we;
    logic            exc_req;
    logic [PC_W-1:0] exc_vec;
    logic            br_req;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus_inc;
    logic            pc_valid;
    logic            flush;
    logic            redir_pending;
    logic            misalign_exc;

    modport master (
        output pc_we, exc_req, exc_vec, br_req, br_target,
        input  pc, pc_plus_inc, pc_valid, flush, redir_pending, misalign_exc
    );

    modport slave (
        input  pc_we, exc_req, exc_vec, br_req, br_target,
        output pc, pc_plus_inc, pc_valid, flush, redir_pending, misalign_exc
    );
endinterface

// File: rtl/pipe_pc_redirect_buf.sv
// One-entry pending-redirect register used while the PC is frozen. An exception always
// overwrites the entry; a branch never overwrites a pending exception.
module pc_redirect_buf
    import pipe_pc_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            capture,
    input  redir_kind_t     kind,
    input  logic [PC_W-1:0] target,
    input  logic            clear,
    output logic            valid,
    output redir_kind_t     pend_kind,
    output logic [PC_W-1:0] pend_target
);

    logic accept;

    always_comb begin
        accept = 1'b0;
        if (capture) begin
            if (kind == EXC)
                accept = 1'b1;
            else if (kind == BR)
                accept = !(valid && (pend_kind == EXC));
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid       <= 1'b0;
            pend_kind   <= NONE;
            pend_target <= '0;
        end else if (clear) begin
            valid     <= 1'b0;
            pend_kind <= NONE;
        end else if (accept) begin
            valid       <= 1'b1;
            pend_kind   <= kind;
            pend_target <= target;
        end
    end

endmodule

// File: rtl/pipe_pc_unit.sv
// Fetch-stage PC: BOOT/RUN/HOLD FSM, priority next-PC mux, incrementer and PC register.
// Define PIPE_PC_MISALIGN_TRAP_EN to trap redirects whose target is not INC-aligned.
module pipe_pc_unit
    import pipe_pc_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(32'h0000_0000),
    parameter int unsigned     INC       = 4,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'h0000_0008)
) (
    input  logic          clk,
    input  logic          clrn,
    pipe_pc_if.slave      bus
);

    pc_state_t       state, state_nxt;
    next_sel_t       sel;
    redir_kind_t     in_kind;
    redir_kind_t     buf_kind;
    logic            buf_valid;
    logic [PC_W-1:0] buf_target;
    logic [PC_W-1:0] in_target;
    logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, redir_target;
    logic            flush_q, flush_nxt;
    logic            mis_nxt;
    logic            active, capture, release_buf;

    assign pc_inc      = pc_q + PC_W'(INC);
    assign active      = (state != BOOT);
    assign capture     = active && !bus.pc_we;
    assign release_buf = active && bus.pc_we;

    // Exception takes the buffer slot over a same-cycle branch.
    always_comb begin
        in_kind   = NONE;
        in_target = bus.br_target;
        if (bus.exc_req) begin
            in_kind   = EXC;
            in_target = bus.exc_vec;
        end else if (bus.br_req) begin
            in_kind = BR;
        end
    end

    pc_redirect_buf #(
        .PC_W (PC_W)
    ) u_redirect_buf (
        .clk         (clk),
        .clrn        (clrn),
        .capture     (capture),
        .kind        (in_kind),
        .target      (in_target),
        .clear       (release_buf),
        .valid       (buf_valid),
        .pend_kind   (buf_kind),
        .pend_target (buf_target)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (!bus.pc_we && (in_kind != NONE)) state_nxt = HOLD;
            HOLD:    if (bus.pc_we) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        sel          = SEL_SEQ;
        redir_target = pc_inc;
        pc_nxt       = pc_q;
        flush_nxt    = 1'b0;
        mis_nxt      = 1'b0;
        bus.pc_valid = active;

        if (release_buf) begin
            if (bus.exc_req)
                sel = SEL_EXC;
            else if (buf_valid && (buf_kind != NONE))
                sel = SEL_PEND;
            else if (bus.br_req)
                sel = SEL_BR;
        end

        case (sel)
            SEL_EXC:  redir_target = bus.exc_vec;
            SEL_PEND: redir_target = buf_target;
            SEL_BR:   redir_target = bus.br_target;
            default:  redir_target = pc_inc;
        endcase

        if (release_buf) begin
            if (sel == SEL_SEQ) begin
                pc_nxt = pc_inc;
            end else begin
                flush_nxt = 1'b1;
`ifdef PIPE_PC_MISALIGN_TRAP_EN
                if (is_misaligned(64'(redir_target), INC)) begin
                    pc_nxt  = TRAP_VEC;
                    mis_nxt = 1'b1;
                end else begin
                    pc_nxt = redir_target;
                end
`else
                pc_nxt = redir_target;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc_q    <= RESET_VEC;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            flush_q <= flush_nxt;
        end
    end

`ifdef PIPE_PC_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            mis_q <= 1'b0;
        else
            mis_q <= mis_nxt;
    end

    assign bus.misalign_exc = mis_q;
`else
    logic unused_trap;

    assign unused_trap      = ^{TRAP_VEC, mis_nxt};
    assign bus.misalign_exc = 1'b0;
`endif

    assign bus.pc            = pc_q;
    assign bus.pc_plus_inc   = pc_inc;
    assign bus.flush         = flush_q;
    assign bus.redir_pending = buf_valid;

endmodule

// File: tb/tb_pipe_pc_unit.sv
// Self-checking bench for pipe_pc_unit: directed scenarios followed by random traffic,
// all compared against a behavioural next-PC model.
module tb_pipe_pc_unit;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0008;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    int checks = 0;
    int errors = 0;

    pipe_pc_if #(.PC_W(32)) bus ();

    pipe_pc_unit #(
        .PC_W      (32),
        .RESET_VEC (RESET_VEC),
        .INC       (4),
        .TRAP_VEC  (TRAP_VEC)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_booted;
    bit          m_flush;
    bit          m_mis;
    bit          p_valid;
    bit          p_exc;
    logic [31:0] p_tgt;

    bit trap_en;

    task automatic model_reset();
        m_pc     = RESET_VEC;
        m_booted = 0;
        m_flush  = 0;
        m_mis    = 0;
        p_valid  = 0;
        p_exc    = 0;
        p_tgt    = '0;
    endtask

    task automatic model_edge(input bit we, input bit exc, input logic [31:0] ev,
                              input bit br, input logic [31:0] bt);
        bit          redirect;
        logic [31:0] t;
        m_flush = 0;
        m_mis   = 0;
        if (!m_booted) begin
            m_booted = 1;
        end else if (we) begin
            redirect = 1;
            t        = '0;
            if (exc)          t = ev;
            else if (p_valid) t = p_tgt;
            else if (br)      t = bt;
            else              redirect = 0;
            p_valid = 0;
            if (redirect) begin
                m_flush = 1;
                if (trap_en && (t % 4 != 0)) begin
                    m_pc  = TRAP_VEC;
                    m_mis = 1;
                end else begin
                    m_pc = t;
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (exc) begin
                p_valid = 1;
                p_exc   = 1;
                p_tgt   = ev;
            end else if (br && !(p_valid && p_exc)) begin
                p_valid = 1;
                p_exc   = 0;
                p_tgt   = bt;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [31:0] inc_exp;
        inc_exp = m_pc + 32'd4;
        chk({where, ":pc"},            bus.pc,                    m_pc);
        chk({where, ":pc_plus_inc"},   bus.pc_plus_inc,           inc_exp);
        chk({where, ":pc_valid"},      32'(bus.pc_valid),         32'(m_booted));
        chk({where, ":flush"},         32'(bus.flush),            32'(m_flush));
        chk({where, ":redir_pending"}, 32'(bus.redir_pending),    32'(p_valid));
        chk({where, ":misalign_exc"},  32'(bus.misalign_exc),     32'(m_mis));
    endtask

    task automatic step(input string where, input bit we, input bit exc, input logic [31:0] ev,
                        input bit br, input logic [31:0] bt);
        bus.pc_we     = we;
        bus.exc_req   = exc;
        bus.exc_vec   = ev;
        bus.br_req    = br;
        bus.br_target = bt;
        @(posedge clk);
        model_edge(we, exc, ev, br, bt);
        #1;
        check_all(where);
    endtask

    initial begin
`ifdef PIPE_PC_MISALIGN_TRAP_EN
        trap_en = 1;
`else
        trap_en = 0;
`endif
        bus.pc_we     = 1'b1;
        bus.exc_req   = 1'b0;
        bus.exc_vec   = '0;
        bus.br_req    = 1'b0;
        bus.br_target = '0;
        model_reset();

        #12;
        check_all("reset");
        #1 clrn = 1'b1;

        // Boot cycle then sequential fetch 0,4,8
        step("boot", 1, 0, 0, 0, 0);
        step("seq4", 1, 0, 0, 0, 0);
        step("seq8", 1, 0, 0, 0, 0);

        step("br40", 1, 0, 0, 1, 32'h40);
        step("after_br", 1, 0, 0, 0, 0);

        // Branch captured while frozen, released two cycles later
        step("stall_br80", 0, 0, 0, 1, 32'h80);
        step("stall_hold1", 0, 0, 0, 0, 0);
        step("stall_hold2", 0, 0, 0, 0, 0);
        step("release80", 1, 0, 0, 0, 0);
        step("after_rel", 1, 0, 0, 0, 0);

        step("exc_vs_br", 1, 1, 32'h100, 1, 32'h40);

        // Pending branch overridden by exception; later branch must not displace it
        step("pend_br", 0, 0, 0, 1, 32'h200);
        step("pend_exc", 0, 1, 32'h300, 0, 0);
        step("pend_br_late", 0, 0, 0, 1, 32'h400);
        step("release_exc", 1, 0, 0, 0, 0);

        step("to_top", 1, 0, 0, 1, 32'hFFFF_FFFC);
        step("wrap", 1, 0, 0, 0, 0);

        // Reset in the middle of a stall with a pending redirect
        step("pre_rst", 0, 0, 0, 1, 32'h500);
        #2 clrn = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        #2 clrn = 1'b1;
        step("reboot", 1, 0, 0, 0, 0);

        step("misalign_br", 1, 0, 0, 1, 32'h42);
        step("after_mis", 1, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            bit          we, exc, br;
            logic [31:0] ev, bt;
            we  = ($urandom_range(0, 3) != 0);
            exc = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 3) == 0);
            ev  = $urandom() & 32'hFFFF_FFFC;
            bt  = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) ev = $urandom();
            if ($urandom_range(0, 7) == 0) bt = $urandom();
            step("random", we, exc, ev, br, bt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
